// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package ex_muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide (restoring); purely combinational.
// Accumulator layout: multiply {partial product, multiplier}, divide {remainder, dividend/quotient}.
module ex_muldiv_unit_muldiv_step
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;

  always_comb begin
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Shifted remainder needs WIDTH+1 bits; the top bit of the difference is the borrow.
    trial   = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    if (div_i) begin
      if (!trial[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/DIV unit owning HI/LO: 34-cycle stall per MULT/DIV, single-cycle MTHI/MTLO.
// Holds the pipeline via o_stall while busy and interlocks MFHI/MFLO until the result lands.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int STEPS = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic             i_flush,
  input  logic             i_read_hilo,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic               take;
  logic               accept_md;
  logic               op_signed;
  logic               op_div;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    take      = i_start && !i_flush;
    accept_md = take && (i_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
    op_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    op_div    = (i_op == MD_DIV) || (i_op == MD_DIVU);
    a_neg     = op_signed && i_data_1[WIDTH-1];
    b_neg     = op_signed && i_data_2[WIDTH-1];
    a_abs     = a_neg ? -i_data_1 : i_data_1;
    b_abs     = b_neg ? -i_data_2 : i_data_2;
  end

  ex_muldiv_unit_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div_q),
    .acc_o  (acc_step)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_md) state_d = ST_RUN;
      ST_RUN: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy  = (state_q != ST_IDLE);
    o_stall = o_busy || ((state_q == ST_IDLE) && accept_md) || (o_busy && i_read_hilo);
  end

  // Remainder follows the dividend sign; a zero divisor still yields the original dividend in HI.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = div0_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_md) begin
          acc_d     = {{WIDTH{1'b0}}, a_abs};
          opnd_d    = b_abs;
          is_div_d  = op_div;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = op_div && (i_data_2 == '0);
          cnt_d     = CW'(STEPS - 1);
        end else if (take && (i_op == MD_MTHI)) begin
          hi_d = i_data_1;
        end else if (take && (i_op == MD_MTLO)) begin
          lo_d = i_data_1;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
      end
      ST_FIX: begin
        if (!i_flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, sign handling, divide corner cases, flush, reset, back-to-back.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [2:0]  i_op;
  logic        i_flush;
  logic        i_read_hilo;
  logic [31:0] i_data_1;
  logic [31:0] i_data_2;
  logic        o_busy;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_total = 0;
  int n_pass  = 0;

  ex_muldiv_unit #(.WIDTH(32), .STEPS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_flush     (i_flush),
    .i_read_hilo (i_read_hilo),
    .i_data_1    (i_data_1),
    .i_data_2    (i_data_2),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  always #5 clk = ~clk;

  // Present one instruction for one cycle; returns o_stall seen in the issue cycle.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic st);
    i_start  = 1'b1;
    i_op     = op;
    i_data_1 = a;
    i_data_2 = b;
    #1;
    st = o_stall;
    @(posedge clk); #1;
    i_start  = 1'b0;
    i_op     = 3'd7;
    i_data_1 = '0;
    i_data_2 = '0;
  endtask

  // Called right after the start edge; counts edges (including the start edge) until o_done.
  task automatic wait_done(output int edges, output int stalls);
    edges  = 1;
    stalls = 0;
    while (!o_done && edges < 100) begin
      if (o_stall) stalls++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; i_start = 0; i_op = 3'd7; i_flush = 0; i_read_hilo = 0;
    i_data_1 = '0; i_data_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else n_pass++;
    n_total++; if (o_hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", o_lo); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    logic st; int e, s;
    start_op(3'd0, 32'hFFFFFFFE, 32'h00000003, st);
    wait_done(e, s);
    n_total++; if (e !== 34) $display("FAIL mult_latency: got %0d want 34", e); else n_pass++;
    n_total++; if (s + int'(st) !== 34) $display("FAIL mult_stall_cycles: got %0d want 34", s + int'(st)); else n_pass++;
    n_total++; if (o_hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h want fffffffa", o_lo); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (o_done !== 1'b0) $display("FAIL mult_done_pulse: got %b want 0", o_done); else n_pass++;
  endtask

  task automatic test_multu;
    logic st; int e, s;
    start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
    wait_done(e, s);
    n_total++; if (e !== 34) $display("FAIL multu_latency: got %0d want 34", e); else n_pass++;
    n_total++; if (o_hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", o_lo); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    logic st; int e, s;
    start_op(3'd2, 32'hFFFFFFF9, 32'h00000002, st);
    wait_done(e, s);
    n_total++; if (e !== 34) $display("FAIL div_latency: got %0d want 34", e); else n_pass++;
    n_total++; if (o_lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want fffffffd", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want ffffffff", o_hi); else n_pass++;
    @(posedge clk); #1;
    start_op(3'd3, 32'd100, 32'd0, st);
    wait_done(e, s);
    n_total++; if (e !== 34) $display("FAIL divu0_latency: got %0d want 34", e); else n_pass++;
    n_total++; if (o_lo !== 32'hFFFFFFFF) $display("FAIL divu0_lo: got %h want ffffffff", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'd100) $display("FAIL divu0_hi: got %h want 00000064", o_hi); else n_pass++;
    @(posedge clk); #1;
    start_op(3'd2, 32'hFFFFFFFB, 32'd0, st);
    wait_done(e, s);
    n_total++; if (o_lo !== 32'hFFFFFFFF) $display("FAIL div0s_lo: got %h want ffffffff", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'hFFFFFFFB) $display("FAIL div0s_hi: got %h want fffffffb", o_hi); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow_mthi;
    logic st; int e, s;
    start_op(3'd2, 32'h80000000, 32'hFFFFFFFF, st);
    wait_done(e, s);
    n_total++; if (o_lo !== 32'h80000000) $display("FAIL ovf_lo: got %h want 80000000", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'h0) $display("FAIL ovf_hi: got %h want 00000000", o_hi); else n_pass++;
    @(posedge clk); #1;
    start_op(3'd4, 32'h00001234, 32'h0, st);
    n_total++; if (st !== 1'b0) $display("FAIL mthi_stall: got %b want 0", st); else n_pass++;
    n_total++; if (o_hi !== 32'h00001234) $display("FAIL mthi_hi: got %h want 00001234", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'h80000000) $display("FAIL mthi_lo_kept: got %h want 80000000", o_lo); else n_pass++;
    n_total++; if (o_done !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL mthi_done_busy: got %b%b want 00", o_done, o_busy); else n_pass++;
    start_op(3'd5, 32'h00005678, 32'h0, st);
    n_total++; if (o_lo !== 32'h00005678) $display("FAIL mtlo_lo: got %h want 00005678", o_lo); else n_pass++;
  endtask

  task automatic test_flush;
    logic st; int dones;
    start_op(3'd4, 32'h0000AAAA, 32'h0, st);
    start_op(3'd5, 32'h00005555, 32'h0, st);
    start_op(3'd0, 32'd5, 32'd7, st);
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    #1;
    n_total++; if (o_stall !== 1'b1) $display("FAIL flush_run_stall: got %b want 1", o_stall); else n_pass++;
    @(posedge clk); #1;
    i_flush = 1'b0;
    n_total++; if (o_busy !== 1'b0) $display("FAIL flush_idle: got %b want 0", o_busy); else n_pass++;
    dones = 0;
    repeat (40) begin
      if (o_done) dones++;
      @(posedge clk); #1;
    end
    n_total++; if (dones !== 0) $display("FAIL flush_no_done: got %0d want 0", dones); else n_pass++;
    n_total++; if (o_hi !== 32'h0000AAAA) $display("FAIL flush_hi: got %h want 0000aaaa", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'h00005555) $display("FAIL flush_lo: got %h want 00005555", o_lo); else n_pass++;
    i_flush = 1'b1;
    start_op(3'd4, 32'h0000BEEF, 32'h0, st);
    n_total++; if (o_hi !== 32'h0000AAAA) $display("FAIL flush_mthi: got %h want 0000aaaa", o_hi); else n_pass++;
    start_op(3'd0, 32'd2, 32'd2, st);
    n_total++; if (st !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL flush_start: got stall %b busy %b want 0 0", st, o_busy); else n_pass++;
    i_flush = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic st; int e, s;
    start_op(3'd0, 32'd6, 32'd7, st);
    i_read_hilo = 1'b1;
    wait_done(e, s);
    n_total++; if (s + int'(st) !== 34) $display("FAIL b2b_stall_cycles: got %0d want 34", s + int'(st)); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL b2b_interlock_release: got %b want 0", o_stall); else n_pass++;
    n_total++; if (o_lo !== 32'd42 || o_hi !== 32'd0)
      $display("FAIL b2b_first: got %h_%h want 00000000_0000002a", o_hi, o_lo); else n_pass++;
    i_read_hilo = 1'b0;
    i_start  = 1'b1;
    i_op     = 3'd0;
    i_data_1 = 32'd3;
    i_data_2 = 32'd4;
    #1;
    n_total++; if (o_done !== 1'b1 || o_stall !== 1'b1)
      $display("FAIL b2b_done_and_stall: got %b%b want 11", o_done, o_stall); else n_pass++;
    @(posedge clk); #1;
    i_start = 1'b0; i_op = 3'd7; i_data_1 = '0; i_data_2 = '0;
    n_total++; if (o_busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", o_busy); else n_pass++;
    wait_done(e, s);
    n_total++; if (e !== 34) $display("FAIL b2b_latency: got %0d want 34", e); else n_pass++;
    n_total++; if (o_lo !== 32'd12 || o_hi !== 32'd0)
      $display("FAIL b2b_second: got %h_%h want 00000000_0000000c", o_hi, o_lo); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic st;
    start_op(3'd0, 32'd9, 32'd9, st);
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (o_busy !== 1'b1) $display("FAIL rstmid_running: got %b want 1", o_busy); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if ({o_busy, o_stall, o_done} !== 3'b000)
      $display("FAIL rstmid_ctrl: got %b want 000", {o_busy, o_stall, o_done}); else n_pass++;
    n_total++; if (o_hi !== 32'h0 || o_lo !== 32'h0)
      $display("FAIL rstmid_hilo: got %h_%h want 0_0", o_hi, o_lo); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_overflow_mthi();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
